// File: rtl/parity_ctrl_pkg.sv
// Purpose : shared types and constants for the serial parity frame controller.
// Latency : n/a (types only).
// Backpressure: n/a (types only).
//
// Contents:
//   ctrl_state_t          controller FSM state encoding
//   PARITY_EVEN/ODD       expected-parity selectors
//   state_is_busy()       true in every state except IDLE
package parity_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2,
    HOLD  = 2'd3
  } ctrl_state_t;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  function automatic logic state_is_busy(input ctrl_state_t s);
    return (s != IDLE);
  endfunction

endpackage

// File: rtl/parity_serial_acc.sv
// Purpose : serial parity / ones accumulator, fed one bit per enabled cycle.
// Latency : state updates on the edge after en; outputs show the post-edge value combinationally.
// Backpressure: none; the caller decides when to clear and when to feed bits.
//
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   clr           clear parity and ones count (wins over en)
//   en, bit_in    accumulate bit_in on this edge when en is high
//   par_out       running XOR of accepted bits, including the bit presented now
//   ones_out      running count of accepted 1s, including the bit presented now
module parity_serial_acc #(
  parameter int ONES_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic              bit_in,
  output logic              par_out,
  output logic [ONES_W-1:0] ones_out
);

  logic              par_q;
  logic              par_d;
  logic [ONES_W-1:0] ones_q;
  logic [ONES_W-1:0] ones_d;
  logic              take_one;

  // Only a 1 changes either the parity or the count.
  assign take_one = en & bit_in;

  always_comb begin
    par_d  = par_q;
    ones_d = ones_q;
    if (clr) begin
      par_d  = 1'b0;
      ones_d = '0;
    end else if (take_one) begin
      par_d  = ~par_q;
      ones_d = ones_q + ONES_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q  <= 1'b0;
      ones_q <= '0;
    end else begin
      par_q  <= par_d;
      ones_q <= ones_d;
    end
  end

  // Mealy view: the result including the bit being presented this cycle.
  // With en and clr low this is simply the stored accumulator.
  assign par_out  = par_d;
  assign ones_out = ones_d;

endmodule

// File: rtl/parity_frame_controller.sv
// Purpose : accepts a parallel frame + parity bit, checks it serially LSB-first, reports error and ones count.
// Latency : out_valid rises DATA_W+1 edges after the accepting edge; minimum frame period DATA_W+3 cycles.
// Backpressure: in_ready low from accept until the cycle after the result handshake; result held while out_ready low.
//
// Ports:
//   clk, rst                    clock and asynchronous active-high reset
//   in_valid/in_ready           frame handshake; in_data + in_parity sampled on the accepting edge
//   out_valid/out_ready         result handshake; out_error + out_ones stable while out_valid
//   err_count                   saturating count of delivered frames with out_error=1
//   busy                        high whenever the controller is not IDLE
module parity_frame_controller
  import parity_ctrl_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int PARITY_MODE = 0,
  parameter int ERRCNT_W    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_data,
  input  logic                        in_parity,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_error,
  output logic [$clog2(DATA_W+1)-1:0] out_ones,
  output logic [ERRCNT_W-1:0]         err_count,
  output logic                        busy
);

  localparam int   ONES_W   = $clog2(DATA_W + 1);
  localparam int   CNT_W    = $clog2(DATA_W);
  localparam logic MODE_BIT = (PARITY_MODE != 0) ? PARITY_ODD : PARITY_EVEN;

  ctrl_state_t         state_q;
  ctrl_state_t         state_d;
  logic [DATA_W-1:0]   shift_q;
  logic [DATA_W-1:0]   shift_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic                par_q;
  logic                par_d;
  logic                out_error_q;
  logic                out_error_d;
  logic [ONES_W-1:0]   out_ones_q;
  logic [ONES_W-1:0]   out_ones_d;
  logic [ERRCNT_W-1:0] err_count_q;
  logic [ERRCNT_W-1:0] err_count_d;

  logic                in_fire;
  logic                out_fire;
  logic                last_bit;
  logic                acc_clr;
  logic                acc_en;
  logic                acc_par;
  logic [ONES_W-1:0]   acc_ones;

  assign in_fire  = in_valid  && (state_q == IDLE);
  assign out_fire = out_ready && (state_q == HOLD);
  assign last_bit = (cnt_q == '0);

  // The accumulator is cleared on the accepting edge so SHIFT starts fresh.
  assign acc_clr = in_fire;
  assign acc_en  = (state_q == SHIFT);

  parity_serial_acc #(
    .ONES_W (ONES_W)
  ) u_acc (
    .clk      (clk),
    .rst      (rst),
    .clr      (acc_clr),
    .en       (acc_en),
    .bit_in   (shift_q[0]),
    .par_out  (acc_par),
    .ones_out (acc_ones)
  );

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = SHIFT;
      SHIFT:   if (last_bit)  state_d = CHECK;
      CHECK:                  state_d = HOLD;
      HOLD:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs decoded from state only
  // ---------------------------------------------------------------------
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == HOLD);
    busy      = state_is_busy(state_q);
  end

  // ---------------------------------------------------------------------
  // Datapath next-value logic
  // ---------------------------------------------------------------------
  always_comb begin
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    par_d       = par_q;
    out_error_d = out_error_q;
    out_ones_d  = out_ones_q;
    err_count_d = err_count_q;

    if (in_fire) begin
      shift_d = in_data;
      par_d   = in_parity;
      cnt_d   = CNT_W'(DATA_W - 1);
    end

    if (state_q == SHIFT) begin
      shift_d = shift_q >> 1;
      // Counter parks at zero once the last bit has been consumed.
      if (!last_bit) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end

    // Accumulator has seen all DATA_W bits by the time we reach CHECK.
    if (state_q == CHECK) begin
      out_error_d = acc_par ^ par_q ^ MODE_BIT;
      out_ones_d  = acc_ones;
    end

    // Count only delivered error frames, and stick at all-ones.
    if (out_fire && out_error_q && (err_count_q != {ERRCNT_W{1'b1}})) begin
      err_count_d = err_count_q + ERRCNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q     <= '0;
      cnt_q       <= '0;
      par_q       <= 1'b0;
      out_error_q <= 1'b0;
      out_ones_q  <= '0;
      err_count_q <= '0;
    end else begin
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      par_q       <= par_d;
      out_error_q <= out_error_d;
      out_ones_q  <= out_ones_d;
      err_count_q <= err_count_d;
    end
  end

  assign out_error = out_error_q;
  assign out_ones  = out_ones_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_parity_frame_controller.sv
// Purpose : self-checking bench; dut0 = even parity / 16-bit counter, dut1 = odd parity / 2-bit counter.
// Latency : model predicts result DATA_W+1 edges after accept.
// Backpressure: random and directed out_ready stalls on both instances.
module tb_parity_frame_controller;

  localparam int DW = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       in_valid;
  logic [1:0]       in_ready;
  logic [1:0][7:0]  in_data;
  logic [1:0]       in_parity;
  logic [1:0]       out_valid;
  logic [1:0]       out_ready;
  logic [1:0]       out_error;
  logic [1:0][3:0]  out_ones;
  logic [1:0]       busy;
  logic [15:0]      err_count0;
  logic [1:0]       err_count1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  parity_frame_controller #(.DATA_W(DW), .PARITY_MODE(0), .ERRCNT_W(16)) dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]), .in_parity(in_parity[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_error(out_error[0]), .out_ones(out_ones[0]),
    .err_count(err_count0), .busy(busy[0])
  );

  parity_frame_controller #(.DATA_W(DW), .PARITY_MODE(1), .ERRCNT_W(2)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]), .in_parity(in_parity[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_error(out_error[1]), .out_ones(out_ones[1]),
    .err_count(err_count1), .busy(busy[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d at time %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Behavioural model: a frame is either waiting to be taken, counting down
  // its fixed latency, or sitting as a result until the consumer takes it.
  // ---------------------------------------------------------------------
  bit m_idle [2];
  bit m_hold [2];
  bit m_err  [2];
  int m_wait [2];
  int m_ones [2];
  int m_cnt  [2];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_idle[k] <= 1'b1;
        m_hold[k] <= 1'b0;
        m_err[k]  <= 1'b0;
        m_wait[k] <= 0;
        m_ones[k] <= 0;
        m_cnt[k]  <= 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (m_idle[k]) begin
          if (in_valid[k]) begin
            // Error when data+parity ones total disagrees with the expected parity.
            m_err[k]  <= ((^in_data[k]) ^ in_parity[k]) != (k == 1);
            m_ones[k] <= $countones(in_data[k]);
            m_idle[k] <= 1'b0;
            m_wait[k] <= DW + 1;
          end
        end else if (!m_hold[k]) begin
          m_wait[k] <= m_wait[k] - 1;
          if (m_wait[k] == 1) m_hold[k] <= 1'b1;
        end else if (out_ready[k]) begin
          m_hold[k] <= 1'b0;
          m_idle[k] <= 1'b1;
          if (m_err[k] && m_cnt[k] < ((k == 0) ? 65535 : 3)) m_cnt[k] <= m_cnt[k] + 1;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("in_ready%0d", k),  32'(in_ready[k]),  32'(m_idle[k]));
        chk($sformatf("busy%0d", k),      32'(busy[k]),      32'(!m_idle[k]));
        chk($sformatf("out_valid%0d", k), 32'(out_valid[k]), 32'(m_hold[k]));
        chk($sformatf("err_count%0d", k), (k == 0) ? 32'(err_count0) : 32'(err_count1), m_cnt[k]);
        if (m_hold[k]) begin
          chk($sformatf("out_error%0d", k), 32'(out_error[k]), 32'(m_err[k]));
          chk($sformatf("out_ones%0d", k),  32'(out_ones[k]),  m_ones[k]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Present a frame and return just after the edge that accepts it.
  task automatic send(input int k, input logic [7:0] d, input logic p, input bit keep_valid);
    bit ok;
    bit acc;
    ok = 1'b0;
    in_valid[k]  = 1'b1;
    in_data[k]   = d;
    in_parity[k] = p;
    for (int i = 0; i < 60; i++) begin
      acc = m_idle[k];
      step();
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 32'(ok), 32'd1);
    if (!keep_valid) in_valid[k] = 1'b0;
  endtask

  // Count edges from the accepting edge until out_valid is seen.
  task automatic wait_valid(input int k, input string nm, input int exp_lat);
    int n;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (out_valid[k]) begin
        n = i;
        break;
      end
    end
    chk(nm, n, exp_lat);
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: actual timeout required completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    in_parity = '0;
    out_ready = 2'b11;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_in_ready",  32'(in_ready[k]),  32'd1);
      chk("rst_out_valid", 32'(out_valid[k]), 32'd0);
      chk("rst_busy",      32'(busy[k]),      32'd0);
      chk("rst_out_error", 32'(out_error[k]), 32'd0);
      chk("rst_out_ones",  32'(out_ones[k]),  32'd0);
    end
    chk("rst_err_count0", 32'(err_count0), 32'd0);
    chk("rst_err_count1", 32'(err_count1), 32'd0);
    #21;
    rst = 1'b0;
    step();

    // 1: clean frame
    send(0, 8'hA5, 1'b0, 1'b0);
    wait_valid(0, "t1_latency", 9);
    chk("t1_error", 32'(out_error[0]), 32'd0);
    chk("t1_ones",  32'(out_ones[0]),  32'd4);
    step();
    chk("t1_err_count", 32'(err_count0), 32'd0);
    chk("t1_ready_back", 32'(in_ready[0]), 32'd1);

    // 2: error frame then clean all-ones frame
    send(0, 8'hA5, 1'b1, 1'b0);
    wait_valid(0, "t2_latency", 9);
    chk("t2_error", 32'(out_error[0]), 32'd1);
    chk("t2_ones",  32'(out_ones[0]),  32'd4);
    step();
    chk("t2_err_count", 32'(err_count0), 32'd1);
    send(0, 8'hFF, 1'b0, 1'b0);
    wait_valid(0, "t2b_latency", 9);
    chk("t2b_error", 32'(out_error[0]), 32'd0);
    chk("t2b_ones",  32'(out_ones[0]),  32'd8);
    step();
    chk("t2b_err_count", 32'(err_count0), 32'd1);

    // 3: backpressure on an error result
    out_ready[0] = 1'b0;
    send(0, 8'h01, 1'b0, 1'b0);
    wait_valid(0, "t3_latency", 9);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_hold_valid",  32'(out_valid[0]), 32'd1);
      chk("t3_hold_error",  32'(out_error[0]), 32'd1);
      chk("t3_hold_ones",   32'(out_ones[0]),  32'd1);
      chk("t3_hold_ready",  32'(in_ready[0]),  32'd0);
      chk("t3_hold_errcnt", 32'(err_count0),   32'd1);
    end
    out_ready[0] = 1'b1;
    step();
    chk("t3_err_count", 32'(err_count0), 32'd2);

    // 4: back-to-back with in_valid held high
    send(0, 8'h00, 1'b0, 1'b1);
    in_data[0]   = 8'h80;
    in_parity[0] = 1'b1;
    wait_valid(0, "t4_latency", 9);
    chk("t4_error", 32'(out_error[0]), 32'd0);
    chk("t4_ones",  32'(out_ones[0]),  32'd0);
    step();
    chk("t4_gap_ready", 32'(in_ready[0]), 32'd1);
    step();
    chk("t4_second_accept", 32'(busy[0]), 32'd1);
    in_valid[0] = 1'b0;
    wait_valid(0, "t4b_latency", 9);
    chk("t4b_error", 32'(out_error[0]), 32'd0);
    chk("t4b_ones",  32'(out_ones[0]),  32'd1);
    step();

    // 5: reset in the middle of SHIFT
    send(0, 8'h3C, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("t5_in_ready",  32'(in_ready[0]),  32'd1);
    chk("t5_busy",      32'(busy[0]),      32'd0);
    chk("t5_out_valid", 32'(out_valid[0]), 32'd0);
    chk("t5_err_count", 32'(err_count0),   32'd0);
    step();
    rst = 1'b0;
    step();
    send(0, 8'h0F, 1'b0, 1'b0);
    wait_valid(0, "t5_latency", 9);
    chk("t5_error", 32'(out_error[0]), 32'd0);
    chk("t5_ones",  32'(out_ones[0]),  32'd4);
    step();

    // Random traffic on both instances; inputs churn freely while busy.
    for (int c = 0; c < 2000; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (!(in_valid[k] && m_idle[k])) begin
          in_valid[k]  = ($urandom_range(0, 2) == 0);
          in_data[k]   = 8'($urandom);
          in_parity[k] = 1'($urandom);
        end
        out_ready[k] = 1'($urandom);
      end
      step();
    end
    in_valid  = '0;
    out_ready = 2'b11;
    repeat (30) step();

    // 6: odd parity and a 2-bit saturating counter
    rst = 1'b1;
    #5;
    rst = 1'b0;
    step();
    chk("t6_rst_err_count", 32'(err_count1), 32'd0);
    send(1, 8'h01, 1'b0, 1'b0);
    wait_valid(1, "t6_latency", 9);
    chk("t6_error", 32'(out_error[1]), 32'd0);
    step();
    chk("t6_err_count", 32'(err_count1), 32'd0);
    for (int i = 0; i < 4; i++) begin
      send(1, 8'h00, 1'b0, 1'b0);
      wait_valid(1, "t6_sat_latency", 9);
      chk("t6_sat_error", 32'(out_error[1]), 32'd1);
      step();
      chk("t6_sat_count", 32'(err_count1), (i + 1 > 3) ? 32'd3 : 32'(i + 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/parity_frame_controller.md
Name: parity_frame_controller

Overview:
Sequences a serial parity-check datapath for parallel frames. Accepts a DATA_W-bit word plus its received parity bit over a valid/ready handshake, and shifts the word LSB-first through a serial parity accumulator. Presents the check result (error flag and ones count) over a second valid/ready handshake. Sits between a parallel producer (e.g. a UART/packet deframer) and the error-reporting logic.

Parameters:
DATA_W, 8, frame width in bits; must be >= 2.
PARITY_MODE, 0, 0 = even parity expected, 1 = odd parity expected.
ERRCNT_W, 16, width of the saturating error-frame counter.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  producer has a frame.
in_ready  output  1  controller can accept a frame.
in_data  input  DATA_W  frame payload.
in_parity  input  1  received parity bit for in_data.
out_valid  output  1  result available.
out_ready  input  1  consumer accepts result.
out_error  output  1  1 = parity mismatch.
out_ones  output  $clog2(DATA_W+1)  number of 1s in payload.
err_count  output  ERRCNT_W  frames delivered with out_error=1, saturating.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset is asynchronous and active-high: rst high → state IDLE, shift reg/bit counter/accumulator cleared. On reset, in_ready=1 (IDLE), out_valid=0, out_error=0, out_ones=0, err_count=0, busy=0.
- FSM states: IDLE, SHIFT, CHECK, HOLD.
- IDLE: in_ready=1. On in_valid&&in_ready edge, latch in_data into the shift reg and in_parity into par_q, clear the accumulator, load bit counter = DATA_W-1, go to SHIFT.
- SHIFT: each edge feeds shift_reg[0] to the accumulator (acc_par ^= bit; ones += bit), shifts right, and decrements the counter. The edge with counter==0 processes the last bit → CHECK. Exactly DATA_W edges are spent in SHIFT.
- CHECK: one edge. Registers out_error = acc_par ^ par_q ^ PARITY_MODE and out_ones = ones, then goes to HOLD.
- HOLD: out_valid=1. out_error and out_ones are stable until the handshake. On out_valid&&out_ready edge: go to IDLE; if out_error, err_count += 1 unless all-ones (saturates, no wrap).
- Latency: out_valid rises DATA_W+1 edges after the accepting edge (9 for DATA_W=8). in_ready returns 1 the cycle after the out handshake; there is no same-cycle bypass. Minimum frame period is DATA_W+3 cycles.
- in_valid/in_data/in_parity are ignored when in_ready=0. Input changes during SHIFT do not affect the result.
- out_ready is ignored outside HOLD.
- out_error/out_ones keep their last value after the handshake; they are only meaningful while out_valid=1.
- rst asserted in any state (including mid-SHIFT or HOLD) aborts the frame: no result is emitted and err_count is cleared.
- All outputs are registered or decoded only from state; no combinational path from inputs to outputs.

Decomposition:
- Package parity_ctrl_pkg: state enum (IDLE, SHIFT, CHECK, HOLD) as typedef ctrl_state_t; constants PARITY_EVEN=1'b0 and PARITY_ODD=1'b1.
- Sub-module parity_serial_acc: the datapath being sequenced.
  - Ports: clk, rst, clr, en, bit_in, par_out, ones_out.
  - Behaviour: a serial Mealy parity/ones accumulator; clr has priority over en.
- Top module holds the FSM, shift reg, bit counter, par_q, result regs and err_count.

Test Plan:
1. DATA_W=8, even. Send 0xA5 with parity 0, out_ready=1 → out_valid 9 cycles after accept, out_error=0, out_ones=4, err_count=0.
2. Send 0xA5 with parity 1 → out_error=1, out_ones=4, err_count=1 after the handshake. Then 0xFF with parity 0 → out_error=0, err_count stays 1.
3. Backpressure: 0x01 with parity 0 (error), out_ready low for 5 cycles → out_valid, out_error=1 and out_ones=1 held; in_ready=0 throughout; err_count increments only on the handshake edge.
4. Back-to-back: in_valid held high with 0x00/0 then 0x80/1 → second frame accepted exactly 1 cycle after the first out handshake. Results: error 0/ones 0, then error 0/ones 1.
5. Reset mid-operation: assert rst 3 cycles into SHIFT → immediately in_ready=1, busy=0, out_valid=0, err_count=0; the next frame 0x0F/0 → out_error=0, out_ones=4.
6. PARITY_MODE=1, ERRCNT_W=2: 0x01/0 → out_error=0. Then four frames 0x00/0 (each an error) → err_count reaches 3 and stays 3.
